multimode_ff_bank: RTL

MULTIMODE_FF_BANK -- requirements
Module: multimode_ff_bank

---
 rtl/multimode_ff_bank.sv | 98 +++++++++
 1 files changed

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH flip-flops sharing a D/T/JK/SR mode select,
// with sticky illegal-SR flags and a saturating change counter.
module multimode_ff_bank #(
  parameter int unsigned            WIDTH   = 8,
  parameter logic [WIDTH-1:0]       RST_VAL = '0,
  parameter int unsigned            CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] sr_err,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             chg_sat
);

  localparam logic [1:0] M_D  = 2'b00;
  localparam logic [1:0] M_T  = 2'b01;
  localparam logic [1:0] M_JK = 2'b10;
  localparam logic [1:0] M_SR = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_ill;
  logic [WIDTH-1:0] w_err_nxt;
  logic             w_chg;
  logic             w_sat;

  always_comb begin
    w_q_nxt = r_q;
    w_ill   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (mode)
        M_D:  w_q_nxt[i] = a[i];
        M_T:  w_q_nxt[i] = r_q[i] ^ a[i];
        M_JK: begin
          unique case ({a[i], b[i]})
            2'b00:   w_q_nxt[i] = r_q[i];
            2'b01:   w_q_nxt[i] = 1'b0;
            2'b10:   w_q_nxt[i] = 1'b1;
            default: w_q_nxt[i] = ~r_q[i];
          endcase
        end
        default: begin
          unique case ({a[i], b[i]})
            2'b00:   w_q_nxt[i] = r_q[i];
            2'b01:   w_q_nxt[i] = 1'b0;
            2'b10:   w_q_nxt[i] = 1'b1;
            default: begin
              w_q_nxt[i] = r_q[i];
              w_ill[i]   = 1'b1;
            end
          endcase
        end
      endcase
    end
  end

  // A fresh illegal SR beats a simultaneous clear on its own channel
  always_comb begin
    w_err_nxt = err_clr ? '0 : r_err;
    if (en && mode == M_SR) begin
      w_err_nxt = w_err_nxt | w_ill;
    end
  end

  assign w_sat = &r_cnt;
  assign w_chg = en && (w_q_nxt != r_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= RST_VAL;
      r_err <= '0;
      r_cnt <= '0;
    end else begin
      if (en) begin
        r_q <= w_q_nxt;
      end
      r_err <= w_err_nxt;
      if (w_chg && !w_sat) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign Q       = r_q;
  assign sr_err  = r_err;
  assign chg_cnt = r_cnt;
  assign chg_sat = w_sat;

endmodule
